pc_seq_ctrl: RTL and testbench

PC_SEQ_CTRL -- requirements
Module: pc_seq_ctrl

---
 rtl/pc_ctrl_pkg.sv | 20 ++
 rtl/pc_redirect_buf.sv | 35 +++
 rtl/pc_seq_ctrl.sv | 122 ++++++++++++
 tb/tb_pc_seq_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/pc_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pc_ctrl_pkg : PC mode encodings and sequencer state type shared with  |
// |               the PC register.                    Rev 1.0            |
// +----------------------------------------------------------------------+
package pc_ctrl_pkg;

  localparam logic [1:0] PC_MODE_SEQ    = 2'b00;
  localparam logic [1:0] PC_MODE_BRANCH = 2'b01;
  localparam logic [1:0] PC_MODE_TRAP   = 2'b10;
  localparam logic [1:0] PC_MODE_DEBUG  = 2'b11;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } pc_state_e;

endpackage
`default_nettype wire

// File: rtl/pc_redirect_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pc_redirect_buf : one-entry pending-branch buffer; set overwrites.    |
// |                                                    Rev 1.0            |
// +----------------------------------------------------------------------+
module pc_redirect_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        set,
  input  logic        clr,
  input  logic [63:0] set_target,
  output logic        valid,
  output logic [63:0] target
);

  logic        r_valid;
  logic [63:0] r_target;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_target <= 64'd0;
    end else if (set) begin
      r_valid  <= 1'b1;
      r_target <= set_target;
    end else if (clr) begin
      r_valid  <= 1'b0;
    end
  end

  assign valid  = r_valid;
  assign target = r_target;

endmodule
`default_nettype wire

// File: rtl/pc_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pc_seq_ctrl : PC sequencing controller (boot/run/halt, branch, trap,  |
// |               debug PC write).                     Rev 1.0            |
// +----------------------------------------------------------------------+
module pc_seq_ctrl
  import pc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        br_valid,
  input  logic [63:0] br_target,
  input  logic        irq_pending,
  input  logic        irq_enable,
  input  logic [63:0] irq_vector,
  input  logic        dbg_halt_req,
  input  logic        dbg_resume_req,
  input  logic        dbg_pc_wr,
  input  logic [63:0] dbg_pc_data,
  input  logic [63:0] pc_cur,
  output logic        pc_en,
  output logic [1:0]  pc_mode_sel,
  output logic [63:0] pc_branch,
  output logic [63:0] pc_interrupt,
  output logic [63:0] pc_debug_addr,
  output logic        flush,
  output logic        trap_taken,
  output logic        halted,
  output logic [63:0] epc
);

  pc_state_e   r_state;
  pc_state_e   w_next_state;
  logic [63:0] r_epc;
  logic        w_take_trap;
  logic        w_buf_set;
  logic        w_buf_clr;
  logic        w_pend_valid;
  logic [63:0] w_pend_target;

  pc_redirect_buf u_redirect_buf (
    .clk        (clk),
    .rst        (rst),
    .set        (w_buf_set),
    .clr        (w_buf_clr),
    .set_target (br_target),
    .valid      (w_pend_valid),
    .target     (w_pend_target)
  );

  // Commands are decoded from the registered state plus live inputs so the
  // PC register acts on the edge that closes the decision cycle.
  always_comb begin
    pc_en         = 1'b0;
    pc_mode_sel   = PC_MODE_SEQ;
    pc_branch     = 64'd0;
    pc_interrupt  = 64'd0;
    pc_debug_addr = 64'd0;
    flush         = 1'b0;
    trap_taken    = 1'b0;
    halted        = 1'b0;
    w_take_trap   = 1'b0;
    w_buf_set     = 1'b0;
    w_buf_clr     = 1'b0;
    w_next_state  = r_state;
    if (!rst) begin
      case (r_state)
        ST_BOOT: w_next_state = ST_RUN;
        ST_RUN: begin
          if (dbg_halt_req) begin
            w_buf_clr    = 1'b1;
            w_next_state = ST_HALTED;
          end else if (stall) begin
            w_buf_set = br_valid;
          end else if (irq_pending && irq_enable) begin
            pc_en        = 1'b1;
            pc_mode_sel  = PC_MODE_TRAP;
            pc_interrupt = irq_vector;
            trap_taken   = 1'b1;
            flush        = 1'b1;
            w_take_trap  = 1'b1;
            w_buf_clr    = 1'b1;
          end else if (br_valid || w_pend_valid) begin
            pc_en       = 1'b1;
            pc_mode_sel = PC_MODE_BRANCH;
            pc_branch   = br_valid ? br_target : w_pend_target;
            flush       = 1'b1;
            w_buf_clr   = 1'b1;
          end else begin
            pc_en       = 1'b1;
            pc_mode_sel = PC_MODE_SEQ;
          end
        end
        ST_HALTED: begin
          halted = 1'b1;
          if (dbg_pc_wr) begin
            pc_en         = 1'b1;
            pc_mode_sel   = PC_MODE_DEBUG;
            pc_debug_addr = dbg_pc_data;
          end
          if (dbg_resume_req) w_next_state = ST_RUN;
        end
        default: w_next_state = ST_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_BOOT;
      r_epc   <= 64'd0;
    end else begin
      r_state <= w_next_state;
      if (w_take_trap) r_epc <= pc_cur;
    end
  end

  assign epc = r_epc;

endmodule
`default_nettype wire

// File: tb/tb_pc_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pc_seq_ctrl : directed scenarios plus random stimulus against an   |
// |                  event-priority reference model.   Rev 1.0            |
// +----------------------------------------------------------------------+
module tb_pc_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        br_valid;
  logic [63:0] br_target;
  logic        irq_pending;
  logic        irq_enable;
  logic [63:0] irq_vector;
  logic        dbg_halt_req;
  logic        dbg_resume_req;
  logic        dbg_pc_wr;
  logic [63:0] dbg_pc_data;
  logic [63:0] pc_cur;
  logic        pc_en;
  logic [1:0]  pc_mode_sel;
  logic [63:0] pc_branch;
  logic [63:0] pc_interrupt;
  logic [63:0] pc_debug_addr;
  logic        flush;
  logic        trap_taken;
  logic        halted;
  logic [63:0] epc;

  pc_seq_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .br_valid       (br_valid),
    .br_target      (br_target),
    .irq_pending    (irq_pending),
    .irq_enable     (irq_enable),
    .irq_vector     (irq_vector),
    .dbg_halt_req   (dbg_halt_req),
    .dbg_resume_req (dbg_resume_req),
    .dbg_pc_wr      (dbg_pc_wr),
    .dbg_pc_data    (dbg_pc_data),
    .pc_cur         (pc_cur),
    .pc_en          (pc_en),
    .pc_mode_sel    (pc_mode_sel),
    .pc_branch      (pc_branch),
    .pc_interrupt   (pc_interrupt),
    .pc_debug_addr  (pc_debug_addr),
    .flush          (flush),
    .trap_taken     (trap_taken),
    .halted         (halted),
    .epc            (epc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int M_BOOT = 0, M_RUN = 1, M_HALTED = 2;
  localparam int EV_IDLE = 0, EV_HALT = 1, EV_HOLD = 2, EV_TRAP = 3,
                 EV_BRANCH = 4, EV_SEQ = 5, EV_DBG = 6;

  int          n_checks = 0;
  int          n_errors = 0;
  int          m_state  = M_BOOT;
  bit          m_pend   = 1'b0;
  logic [63:0] m_ptgt   = 64'd0;
  logic [63:0] m_epc    = 64'd0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Picks the winning event for this cycle, checks every output against it,
  // then advances the model to the post-edge state.
  task automatic sample();
    int          ev;
    logic        e_en, e_flush, e_trap, e_halt;
    logic [1:0]  e_mode;
    logic [63:0] e_br, e_irq, e_dbg;
    @(negedge clk);
    ev = EV_IDLE;
    if (!rst) begin
      if (m_state == M_RUN) begin
        if (dbg_halt_req)                 ev = EV_HALT;
        else if (stall)                   ev = EV_HOLD;
        else if (irq_pending && irq_enable) ev = EV_TRAP;
        else if (br_valid || m_pend)      ev = EV_BRANCH;
        else                              ev = EV_SEQ;
      end else if (m_state == M_HALTED && dbg_pc_wr) begin
        ev = EV_DBG;
      end
    end
    e_en    = (ev == EV_TRAP || ev == EV_BRANCH || ev == EV_SEQ || ev == EV_DBG);
    e_mode  = (ev == EV_BRANCH) ? 2'b01 : (ev == EV_TRAP) ? 2'b10 : (ev == EV_DBG) ? 2'b11 : 2'b00;
    e_br    = (ev == EV_BRANCH) ? (br_valid ? br_target : m_ptgt) : 64'd0;
    e_irq   = (ev == EV_TRAP) ? irq_vector : 64'd0;
    e_dbg   = (ev == EV_DBG) ? dbg_pc_data : 64'd0;
    e_flush = (ev == EV_TRAP || ev == EV_BRANCH);
    e_trap  = (ev == EV_TRAP);
    e_halt  = !rst && (m_state == M_HALTED);
    check_val("pc_en", pc_en, e_en);
    check_val("pc_mode_sel", pc_mode_sel, e_mode);
    check_val("pc_branch", pc_branch, e_br);
    check_val("pc_interrupt", pc_interrupt, e_irq);
    check_val("pc_debug_addr", pc_debug_addr, e_dbg);
    check_val("flush", flush, e_flush);
    check_val("trap_taken", trap_taken, e_trap);
    check_val("halted", halted, e_halt);
    check_val("epc", epc, m_epc);
    if (rst) begin
      m_state = M_BOOT;
      m_pend  = 1'b0;
      m_epc   = 64'd0;
    end else begin
      case (ev)
        EV_HALT:   begin m_state = M_HALTED; m_pend = 1'b0; end
        EV_HOLD:   if (br_valid) begin m_pend = 1'b1; m_ptgt = br_target; end
        EV_TRAP:   begin m_epc = pc_cur; m_pend = 1'b0; end
        EV_BRANCH: m_pend = 1'b0;
        default:   ;
      endcase
      if (m_state == M_BOOT) m_state = M_RUN;
      else if (m_state == M_HALTED && ev != EV_HALT && dbg_resume_req) m_state = M_RUN;
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; br_valid = 0; irq_pending = 0; irq_enable = 0;
    dbg_halt_req = 0; dbg_resume_req = 0; dbg_pc_wr = 0;
  endtask

  initial begin
    rst = 1; idle_inputs();
    br_target = 0; irq_vector = 0; dbg_pc_data = 0; pc_cur = 0;
    advance();
    sample(); advance();

    // Boot: one cycle with pc_en low, then sequential fetch.
    rst = 0;
    sample(); check_val("boot_en", pc_en, 0); advance();
    for (int i = 0; i < 3; i++) begin
      sample(); check_val("seq_en", pc_en, 1); check_val("seq_mode", pc_mode_sel, 0); advance();
    end

    // Branch while stalled is held, then issued when the stall clears.
    stall = 1; br_valid = 1; br_target = 64'h1000;
    sample(); check_val("stall_en", pc_en, 0); advance();
    br_valid = 0; br_target = 64'h0;
    sample(); check_val("stall_en2", pc_en, 0); advance();
    stall = 0;
    sample(); check_val("pend_mode", pc_mode_sel, 1); check_val("pend_tgt", pc_branch, 64'h1000);
    check_val("pend_flush", flush, 1); advance();
    sample(); check_val("post_br_mode", pc_mode_sel, 0); advance();

    // Trap beats a simultaneous branch.
    irq_pending = 1; irq_enable = 1; br_valid = 1; br_target = 64'h2000;
    pc_cur = 64'h40; irq_vector = 64'h800;
    sample(); check_val("trap_mode", pc_mode_sel, 2); check_val("trap_vec", pc_interrupt, 64'h800);
    check_val("trap_taken", trap_taken, 1); advance();
    idle_inputs();
    sample(); check_val("trap_epc", epc, 64'h40); check_val("no_br_after_trap", pc_mode_sel, 0); advance();

    // Halt, debug PC write, resume.
    dbg_halt_req = 1;
    sample(); check_val("halt_en", pc_en, 0); advance();
    dbg_halt_req = 0; dbg_pc_wr = 1; dbg_pc_data = 64'h3000;
    sample(); check_val("halted", halted, 1); check_val("dbg_mode", pc_mode_sel, 3);
    check_val("dbg_addr", pc_debug_addr, 64'h3000); advance();
    dbg_pc_wr = 0; dbg_resume_req = 1;
    sample(); advance();
    dbg_resume_req = 0;
    sample(); check_val("resume_halted", halted, 0); check_val("resume_mode", pc_mode_sel, 0);
    check_val("resume_en", pc_en, 1); advance();

    // Reset while halted after a stalled branch was latched.
    stall = 1; br_valid = 1; br_target = 64'h5000;
    sample(); advance();
    br_valid = 0; dbg_halt_req = 1;
    sample(); advance();
    dbg_halt_req = 0; stall = 0; rst = 1;
    sample(); check_val("rst_halted", halted, 0); check_val("rst_en", pc_en, 0); advance();
    rst = 0;
    sample(); check_val("reboot_en", pc_en, 0); advance();
    sample(); check_val("reboot_no_br", pc_mode_sel, 0); check_val("reboot_flush", flush, 0); advance();

    // Randomized traffic checked cycle by cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      rst            = ($urandom_range(0, 59) == 0);
      stall          = ($urandom_range(0, 2) == 0);
      br_valid       = ($urandom_range(0, 3) == 0);
      br_target      = {$urandom, $urandom};
      irq_pending    = ($urandom_range(0, 5) == 0);
      irq_enable     = ($urandom_range(0, 1) == 0);
      irq_vector     = {$urandom, $urandom};
      dbg_halt_req   = ($urandom_range(0, 15) == 0);
      dbg_resume_req = ($urandom_range(0, 3) == 0);
      dbg_pc_wr      = ($urandom_range(0, 3) == 0);
      dbg_pc_data    = {$urandom, $urandom};
      pc_cur         = {$urandom, $urandom};
      sample(); advance();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
